datapath_run_ctrl: RTL and testbench

DATAPATH_RUN_CTRL -- requirements
Module: datapath_run_ctrl

---
 rtl/datapath_run_ctrl_if.sv | 32 +++
 rtl/datapath_run_ctrl.sv | 129 ++++++++++++
 tb/tb_datapath_run_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_run_ctrl_if.sv
// Run-control bus between a host/sequencer and datapath_run_ctrl.
//   master : drives run requests, breakpoint setup and the datapath PC
//   slave  : returns per-domain core resets, clock enable, cycle count, status
interface datapath_run_ctrl_if #(
   parameter int NUM_DOMAINS = 2,
   parameter int CNT_WIDTH   = 16,
   parameter int PC_WIDTH    = 32
);
   logic                   start;
   logic                   step_mode;
   logic                   step;
   logic                   halt_req;
   logic                   bp_en;
   logic [PC_WIDTH-1:0]    bp_addr;
   logic [PC_WIDTH-1:0]    pc_in;
   logic [NUM_DOMAINS-1:0] core_rst;
   logic                   core_en;
   logic [CNT_WIDTH-1:0]   cycle_count;
   logic                   running;
   logic                   done;
   logic                   halted_bp;

   modport master (
      output start, step_mode, step, halt_req, bp_en, bp_addr, pc_in,
      input  core_rst, core_en, cycle_count, running, done, halted_bp
   );

   modport slave (
      input  start, step_mode, step, halt_req, bp_en, bp_addr, pc_in,
      output core_rst, core_en, cycle_count, running, done, halted_bp
   );
endinterface

// File: rtl/datapath_run_ctrl.sv
// Datapath run controller: releases staggered per-domain core resets after
// start, then gates the datapath clock enable for a free run or single-step
// run, stopping on cycle budget, halt request or PC breakpoint.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : datapath_run_ctrl_if.slave (requests in, resets/enable/status out)
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | all core resets held, waiting for start
// S_RESET | timer counting down, core resets released domain by domain
// S_RUN   | free run, core_en every cycle unless breakpoint matches
// S_STEP  | single-step, core_en only in cycles with step asserted
// S_DONE  | run finished, count and halted_bp held for inspection
module datapath_run_ctrl #(
   parameter int NUM_DOMAINS = 2,
   parameter int RST_CYCLES  = 2,
   parameter int STAGGER     = 1,
   parameter int RUN_CYCLES  = 25,
   parameter int CNT_WIDTH   = 16,
   parameter int PC_WIDTH    = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   datapath_run_ctrl_if.slave   bus
);

   typedef enum logic [2:0] {S_IDLE, S_RESET, S_RUN, S_STEP, S_DONE} state_t;

   // Timer is loaded with the total reset window and counts down to zero;
   // domain d is released once the remaining time drops to its share of
   // the stagger still owed to the higher domains.
   localparam int T_TOTAL = RST_CYCLES + (NUM_DOMAINS - 1) * STAGGER;
   localparam int TMR_W   = $clog2(T_TOTAL + 2);

   state_t                 state_q, state_d;
   logic [TMR_W-1:0]       timer_q, timer_d, timer_nxt;
   logic [NUM_DOMAINS-1:0] core_rst_q, core_rst_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, cnt_inc;
   logic                   step_mode_q, step_mode_d;
   logic                   running_q, running_d;
   logic                   done_q, done_d;
   logic                   halted_bp_q, halted_bp_d;
   logic                   bp_hit, core_en, limit_hit;

   assign bp_hit    = bus.bp_en && (bus.pc_in == bus.bp_addr);
   assign core_en   = ((state_q == S_RUN) || ((state_q == S_STEP) && bus.step)) && !bp_hit;
   assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
   assign limit_hit = (RUN_CYCLES != 0) && core_en && (cnt_inc == CNT_WIDTH'(RUN_CYCLES));
   assign timer_nxt = (timer_q == '0) ? '0 : timer_q - TMR_W'(1);

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      core_rst_d  = core_rst_q;
      cnt_d       = cnt_q;
      step_mode_d = step_mode_q;
      halted_bp_d = halted_bp_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            core_rst_d = (state_q == S_IDLE) ? '1 : '0;
            if (bus.start) begin
               state_d     = S_RESET;
               timer_d     = TMR_W'(T_TOTAL);
               core_rst_d  = '1;
               cnt_d       = '0;
               halted_bp_d = 1'b0;
               step_mode_d = bus.step_mode;
            end
         end
         S_RESET: begin
            timer_d = timer_nxt;
            for (int d = 0; d < NUM_DOMAINS; d++) begin
               if (timer_nxt <= TMR_W'((NUM_DOMAINS - 1 - d) * STAGGER))
                  core_rst_d[d] = 1'b0;
            end
            if (timer_q <= TMR_W'(1)) begin
               state_d    = step_mode_q ? S_STEP : S_RUN;
               core_rst_d = '0;
            end
         end
         S_RUN, S_STEP: begin
            if (core_en)
               cnt_d = cnt_inc;
            // Limit, halt and breakpoint collapse into a single transition.
            if (limit_hit || bus.halt_req || bp_hit)
               state_d = S_DONE;
            if (bp_hit)
               halted_bp_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      running_d = (state_d == S_RUN) || (state_d == S_STEP);
      done_d    = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         timer_q     <= '0;
         core_rst_q  <= '1;
         cnt_q       <= '0;
         step_mode_q <= 1'b0;
         running_q   <= 1'b0;
         done_q      <= 1'b0;
         halted_bp_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         core_rst_q  <= core_rst_d;
         cnt_q       <= cnt_d;
         step_mode_q <= step_mode_d;
         running_q   <= running_d;
         done_q      <= done_d;
         halted_bp_q <= halted_bp_d;
      end
   end

   assign bus.core_rst    = core_rst_q;
   assign bus.core_en     = core_en;
   assign bus.cycle_count = cnt_q;
   assign bus.running     = running_q;
   assign bus.done        = done_q;
   assign bus.halted_bp   = halted_bp_q;

endmodule

// File: tb/tb_datapath_run_ctrl.sv
// Testbench for datapath_run_ctrl with default parameters. Stimulus pushes
// expected snapshots (per cycle) and expected end-of-run records into queues;
// a negedge monitor pops and compares them as the DUT reaches those points.
module tb_datapath_run_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   datapath_run_ctrl_if #(.NUM_DOMAINS(2), .CNT_WIDTH(16), .PC_WIDTH(32)) bus ();

   datapath_run_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      string       name;
      int          cyc;
      logic [1:0]  crst;
      logic        en;
      logic        run;
      logic        dn;
      logic        hbp;
      logic [15:0] cnt;
   } snap_t;

   typedef struct {
      string       name;
      logic [15:0] cnt;
      logic        hbp;
      int          en_cycles;
   } done_t;

   snap_t snap_q[$];
   done_t done_q[$];
   int    cyc      = 0;
   int    n_checks = 0;
   int    n_pass   = 0;
   int    en_cnt   = 0;
   logic  done_prev = 1'b0;
   snap_t s;
   done_t d;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic exp_snap(input string nm, input int at, input logic [1:0] crst,
                           input logic en, input logic run, input logic dn,
                           input logic hbp, input logic [15:0] cnt);
      snap_t e;
      e.name = nm; e.cyc = at; e.crst = crst; e.en = en;
      e.run = run; e.dn = dn; e.hbp = hbp; e.cnt = cnt;
      snap_q.push_back(e);
   endtask

   task automatic exp_done(input string nm, input logic [15:0] cnt, input logic hbp,
                           input int en_cycles);
      done_t e;
      e.name = nm; e.cnt = cnt; e.hbp = hbp; e.en_cycles = en_cycles;
      done_q.push_back(e);
   endtask

   // Pulse start for one cycle; e0 is the edge that enters RESET.
   task automatic do_start(input logic sm, output int e0);
      bus.start     = 1'b1;
      bus.step_mode = sm;
      tick(1);
      bus.start     = 1'b0;
      bus.step_mode = 1'b0;
      e0 = cyc;
   endtask

   task automatic run_default(input string nm);
      int e0;
      do_start(1'b0, e0);
      exp_snap({nm, "_e0"},   e0,      2'b11, 0, 0, 0, 0, 16'd0);
      exp_snap({nm, "_e1"},   e0 + 1,  2'b11, 0, 0, 0, 0, 16'd0);
      exp_snap({nm, "_e2"},   e0 + 2,  2'b10, 0, 0, 0, 0, 16'd0);
      exp_snap({nm, "_run"},  e0 + 3,  2'b00, 1, 1, 0, 0, 16'd0);
      exp_snap({nm, "_c1"},   e0 + 4,  2'b00, 1, 1, 0, 0, 16'd1);
      exp_snap({nm, "_c24"},  e0 + 27, 2'b00, 1, 1, 0, 0, 16'd24);
      exp_snap({nm, "_done"}, e0 + 28, 2'b00, 0, 0, 1, 0, 16'd25);
      exp_done(nm, 16'd25, 1'b0, 25);
      tick(30);
   endtask

   always @(negedge clk) begin
      if (bus.core_rst == 2'b11)
         en_cnt = 0;
      else if (bus.core_en)
         en_cnt++;

      while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
         s = snap_q.pop_front();
         n_checks++;
         if (s.cyc != cyc)
            $display("FAIL %s: snapshot for cycle %0d missed (now %0d)", s.name, s.cyc, cyc);
         else if (bus.core_rst !== s.crst || bus.core_en !== s.en || bus.running !== s.run ||
                  bus.done !== s.dn || bus.halted_bp !== s.hbp || bus.cycle_count !== s.cnt)
            $display("FAIL %s@%0d: got core_rst=%b core_en=%b running=%b done=%b halted_bp=%b cycle_count=%0d, want %b %b %b %b %b %0d",
                     s.name, cyc, bus.core_rst, bus.core_en, bus.running, bus.done,
                     bus.halted_bp, bus.cycle_count, s.crst, s.en, s.run, s.dn, s.hbp, s.cnt);
         else
            n_pass++;
      end

      if (bus.done === 1'b1 && done_prev !== 1'b1) begin
         n_checks++;
         if (done_q.size() == 0) begin
            $display("FAIL unexpected_done@%0d: done rose with no run outstanding", cyc);
         end else begin
            d = done_q.pop_front();
            if (bus.cycle_count !== d.cnt || bus.halted_bp !== d.hbp || en_cnt != d.en_cycles)
               $display("FAIL %s_end: got cycle_count=%0d halted_bp=%b en_cycles=%0d, want %0d %b %0d",
                        d.name, bus.cycle_count, bus.halted_bp, en_cnt, d.cnt, d.hbp, d.en_cycles);
            else
               n_pass++;
         end
      end
      done_prev = bus.done;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int e0;
      bus.start     = 1'b0;
      bus.step_mode = 1'b0;
      bus.step      = 1'b0;
      bus.halt_req  = 1'b0;
      bus.bp_en     = 1'b0;
      bus.bp_addr   = 32'h0;
      bus.pc_in     = 32'h0;

      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      exp_snap("reset", cyc, 2'b11, 0, 0, 0, 0, 16'd0);
      tick(1);

      run_default("run");
      run_default("restart");

      // Breakpoint at 0x0C: PC advances by 4 per enabled cycle.
      bus.bp_en   = 1'b1;
      bus.bp_addr = 32'h0000_000C;
      bus.pc_in   = 32'h0;
      do_start(1'b0, e0);
      exp_snap("bp_run",  e0 + 3, 2'b00, 1, 1, 0, 0, 16'd0);
      exp_snap("bp_hit",  e0 + 6, 2'b00, 0, 1, 0, 0, 16'd3);
      exp_snap("bp_done", e0 + 7, 2'b00, 0, 0, 1, 1, 16'd3);
      exp_done("bp", 16'd3, 1'b1, 3);
      tick(4); bus.pc_in = 32'h4;
      tick(1); bus.pc_in = 32'h8;
      tick(1); bus.pc_in = 32'hC;
      tick(3);
      bus.bp_en = 1'b0;
      bus.pc_in = 32'h0;

      // Single-step: three pulses four cycles apart, then halt.
      do_start(1'b1, e0);
      exp_snap("step_e0",   e0,      2'b11, 0, 0, 0, 0, 16'd0);
      exp_snap("step_idle", e0 + 3,  2'b00, 0, 1, 0, 0, 16'd0);
      exp_snap("step_p1",   e0 + 4,  2'b00, 1, 1, 0, 0, 16'd0);
      exp_snap("step_mid",  e0 + 9,  2'b00, 0, 1, 0, 0, 16'd2);
      exp_snap("step_p3",   e0 + 12, 2'b00, 1, 1, 0, 0, 16'd2);
      exp_snap("step_c3",   e0 + 13, 2'b00, 0, 1, 0, 0, 16'd3);
      exp_snap("step_done", e0 + 17, 2'b00, 0, 0, 1, 0, 16'd3);
      exp_done("step", 16'd3, 1'b0, 3);
      tick(4);  bus.step = 1'b1;
      tick(1);  bus.step = 1'b0;
      tick(3);  bus.step = 1'b1;
      tick(1);  bus.step = 1'b0;
      tick(3);  bus.step = 1'b1;
      tick(1);  bus.step = 1'b0;
      tick(3);  bus.halt_req = 1'b1;
      tick(1);  bus.halt_req = 1'b0;
      tick(2);

      // Halt on the 10th RUN cycle.
      do_start(1'b0, e0);
      exp_snap("halt_c9",   e0 + 12, 2'b00, 1, 1, 0, 0, 16'd9);
      exp_snap("halt_done", e0 + 13, 2'b00, 0, 0, 1, 0, 16'd10);
      exp_done("halt", 16'd10, 1'b0, 10);
      tick(12); bus.halt_req = 1'b1;
      tick(1);  bus.halt_req = 1'b0;
      tick(2);

      // Reset in the middle of a run.
      do_start(1'b0, e0);
      exp_snap("rstmid_c7",   e0 + 10, 2'b00, 1, 1, 0, 0, 16'd7);
      exp_snap("rstmid_idle", e0 + 11, 2'b11, 0, 0, 0, 0, 16'd0);
      tick(10); rst = 1'b1;
      tick(1);  rst = 1'b0;
      tick(3);

      n_checks++;
      if (snap_q.size() != 0)
         $display("FAIL snap_drain: %0d snapshots left unchecked, want 0", snap_q.size());
      else
         n_pass++;
      n_checks++;
      if (done_q.size() != 0)
         $display("FAIL done_drain: %0d run ends never seen, want 0", done_q.size());
      else
         n_pass++;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
